prio_queue: RTL and testbench

Single-clock sorted priority queue: a parametrised successor of the team's insert-only priority register array, with a pop port, valid/ready handshakes, per-slot occupancy and a selectable full-queue policy. Entries are kept sorted with the highest priority in slot 0. The block sits between a scoring stage (sink) and a consumer that drains best-first (source).

---
 rtl/prio_queue_pkg.sv | 16 +
 rtl/prio_queue_slot.sv | 68 ++++++
 rtl/prio_queue.sv | 101 ++++++++++
 tb/tb_prio_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/prio_queue_pkg.sv
// Shared constants for the sorted priority queue: full-queue policies and
// the per-slot next-state selector.
package prio_queue_pkg;

  localparam int FULL_REJECT = 0;
  localparam int FULL_EVICT  = 1;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_LEFT,
    SEL_RIGHT,
    SEL_IN,
    SEL_CLR
  } slot_sel_e;

endpackage

// File: rtl/prio_queue_slot.sv
// One slot of the sorted queue. Record layout is {valid, prio, data}, MSB first.
// The slot decides its own next state from its compare and its neighbours' compares.
module prio_queue_slot
  import prio_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int PRIO_WIDTH = 32,
  parameter bit FIRST      = 1'b0,
  parameter int REC_W      = 1 + PRIO_WIDTH + DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [REC_W-1:0] left_i,
  input  logic [REC_W-1:0] right_i,
  input  logic [REC_W-1:0] in_i,
  input  logic             left_ins_i,
  input  logic             right_ins_i,
  output logic             ins_o,
  output logic [REC_W-1:0] rec_o
);

  logic [REC_W-1:0]      rec_q, rec_d;
  logic                  own_valid;
  logic [PRIO_WIDTH-1:0] own_prio, in_prio;
  slot_sel_e             sel;

  assign own_valid = rec_q[REC_W-1];
  assign own_prio  = rec_q[PRIO_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign in_prio   = in_i[PRIO_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

  // Strict compare keeps older entries ahead of equal-priority newcomers.
  assign ins_o = !own_valid || (in_prio > own_prio);

  // With a simultaneous pop the array is viewed shifted up by one, so the
  // left-neighbour compare of that view is this slot's own compare.
  always_comb begin
    sel = SEL_HOLD;
    if (clr_i)
      sel = SEL_CLR;
    else if (push_i && pop_i) begin
      if (ins_o && !FIRST) sel = SEL_HOLD;
      else if (right_ins_i) sel = SEL_IN;
      else                  sel = SEL_RIGHT;
    end else if (push_i) begin
      if (left_ins_i) sel = SEL_LEFT;
      else if (ins_o) sel = SEL_IN;
    end else if (pop_i)
      sel = SEL_RIGHT;
  end

  always_comb begin
    rec_d = rec_q;
    case (sel)
      SEL_LEFT:  rec_d = left_i;
      SEL_RIGHT: rec_d = right_i;
      SEL_IN:    rec_d = in_i;
      SEL_CLR:   rec_d = '0;
      default:   rec_d = rec_q;
    endcase
  end

  always_ff @(posedge clk_i) rec_q <= rec_d;

  assign rec_o = rec_q;

endmodule

// File: rtl/prio_queue.sv
// Sorted priority queue, best entry in slot 0. Handles the handshakes,
// occupancy count, full-queue policy and the registered drop pulse.
module prio_queue
  import prio_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int PRIO_WIDTH = 32,
  parameter int TOT_SIZE   = 4,
  parameter int FULL_MODE  = FULL_REJECT
) (
  input  logic                          sink_clk,
  input  logic                          reset,
  input  logic                          sink_valid,
  output logic                          sink_ready,
  input  logic [DATA_WIDTH-1:0]         sink_data,
  input  logic [PRIO_WIDTH-1:0]         sink_prio,
  output logic                          source_valid,
  input  logic                          source_ready,
  output logic [DATA_WIDTH-1:0]         source_data,
  output logic [PRIO_WIDTH-1:0]         source_prio,
  output logic [$clog2(TOT_SIZE+1)-1:0] count,
  output logic                          drop
);

  localparam int CW    = $clog2(TOT_SIZE+1);
  localparam int REC_W = 1 + PRIO_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [PRIO_WIDTH-1:0] prio;
    logic [DATA_WIDTH-1:0] data;
  } rec_t;

  // Slots padded with an empty record at each end; ins_ext likewise, with the
  // slot past the end always accepting the newcomer.
  rec_t            ext [TOT_SIZE+2];
  logic [TOT_SIZE+1:0] ins_ext;
  rec_t            in_rec;

  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d;
  logic          full, push_fire, pop_fire, do_push;

  assign ext[0]            = '0;
  assign ext[TOT_SIZE+1]   = '0;
  assign ins_ext[0]        = 1'b0;
  assign ins_ext[TOT_SIZE+1] = 1'b1;
  assign in_rec            = '{valid: 1'b1, prio: sink_prio, data: sink_data};

  for (genvar i = 0; i < TOT_SIZE; i++) begin : g_slot
    prio_queue_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .PRIO_WIDTH (PRIO_WIDTH),
      .FIRST      (i == 0)
    ) u_slot (
      .clk_i       (sink_clk),
      .clr_i       (reset),
      .push_i      (do_push),
      .pop_i       (pop_fire),
      .left_i      (ext[i]),
      .right_i     (ext[i+2]),
      .in_i        (in_rec),
      .left_ins_i  (ins_ext[i]),
      .right_ins_i (ins_ext[i+2]),
      .ins_o       (ins_ext[i+1]),
      .rec_o       (ext[i+1])
    );
  end

  assign full       = (count_q == CW'(TOT_SIZE));
  assign sink_ready = (FULL_MODE == FULL_EVICT) ? 1'b1 : !full;
  assign push_fire  = sink_valid && sink_ready;
  assign pop_fire   = source_ready && (count_q != '0);

  // Full with no pop: only a strictly better newcomer displaces the tail.
  assign do_push = push_fire && (!full || pop_fire || (sink_prio > ext[TOT_SIZE].prio));
  assign drop_d  = push_fire && full && !pop_fire;

  always_comb begin
    count_d = count_q;
    if (push_fire && !pop_fire && !full) count_d = count_q + 1'b1;
    else if (pop_fire && !push_fire)     count_d = count_q - 1'b1;
  end

  always_ff @(posedge sink_clk) begin
    if (reset) begin
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign count        = count_q;
  assign drop         = drop_q;
  assign source_valid = (count_q != '0);
  assign source_data  = ext[1].data;
  assign source_prio  = ext[1].prio;

endmodule

// File: tb/tb_prio_queue.sv
// Bench for prio_queue: a reject-mode and an evict-mode instance driven from a
// vector table and a random run, checked against a sorted software queue.
module tb_prio_queue;

  typedef struct {
    logic [31:0] p;
    logic [9:0]  d;
  } ent_t;

  typedef struct {
    bit          m;
    bit          r;
    bit          push;
    bit          pop;
    logic [31:0] p;
    logic [9:0]  d;
    int          ecnt;
    logic [31:0] ehead;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v[2], rdy[2];
  logic [9:0]  sdata = '0;
  logic [31:0] sprio = '0;
  logic        srd[2], sv[2], drp[2];
  logic [9:0]  sd[2];
  logic [31:0] sp[2];
  logic [2:0]  cnt[2];

  ent_t mq[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  prio_queue #(.DATA_WIDTH(10), .PRIO_WIDTH(32), .TOT_SIZE(4), .FULL_MODE(0)) u0 (
    .sink_clk(clk), .reset(rst), .sink_valid(v[0]), .sink_ready(srd[0]),
    .sink_data(sdata), .sink_prio(sprio), .source_valid(sv[0]), .source_ready(rdy[0]),
    .source_data(sd[0]), .source_prio(sp[0]), .count(cnt[0]), .drop(drp[0]));

  prio_queue #(.DATA_WIDTH(10), .PRIO_WIDTH(32), .TOT_SIZE(4), .FULL_MODE(1)) u1 (
    .sink_clk(clk), .reset(rst), .sink_valid(v[1]), .sink_ready(srd[1]),
    .sink_data(sdata), .sink_prio(sprio), .source_valid(sv[1]), .source_ready(rdy[1]),
    .source_data(sd[1]), .source_prio(sp[1]), .count(cnt[1]), .drop(drp[1]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Sorted insert, behind every entry of equal or higher priority.
  task automatic minsert(input logic [31:0] p, input logic [9:0] d);
    int   k;
    ent_t e;
    k = mq.size();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].p < p) begin
        k = i;
        break;
      end
    e.p = p;
    e.d = d;
    mq.insert(k, e);
  endtask

  task automatic do_op(input bit m, input bit r, input bit push, input bit pop,
                       input logic [31:0] p, input logic [9:0] d);
    int mi;
    bit full, dpop, acc, edrop;
    mi = m ? 1 : 0;
    v[0] = 1'b0; v[1] = 1'b0; rdy[0] = 1'b0; rdy[1] = 1'b0;
    v[mi] = push; rdy[mi] = pop; sprio = p; sdata = d;
    if (r) begin
      rst = 1'b1;
      step();
      rst = 1'b0; v[mi] = 1'b0; rdy[mi] = 1'b0;
      mq.delete();
      chk("rst_count", 64'(cnt[mi]), 0);
      chk("rst_valid", 64'(sv[mi]), 0);
      chk("rst_data",  64'(sd[mi]), 0);
      chk("rst_prio",  64'(sp[mi]), 0);
      chk("rst_drop",  64'(drp[mi]), 0);
      chk("rst_ready", 64'(srd[mi]), 1);
      return;
    end
    chk("sink_ready", 64'(srd[mi]), 64'(mi == 1 || mq.size() < 4));
    if (pop && mq.size() > 0) begin
      chk("pop_prio", 64'(sp[mi]), 64'(mq[0].p));
      chk("pop_data", 64'(sd[mi]), 64'(mq[0].d));
    end
    full  = (mq.size() == 4);
    dpop  = pop && (mq.size() > 0);
    acc   = push && (mi == 1 || !full);
    edrop = 1'b0;
    if (dpop) void'(mq.pop_front());
    if (acc) begin
      if (full && !dpop) begin
        edrop = 1'b1;
        if (p > mq[3].p) begin
          void'(mq.pop_back());
          minsert(p, d);
        end
      end else
        minsert(p, d);
    end
    step();
    v[mi] = 1'b0; rdy[mi] = 1'b0;
    chk("count", 64'(cnt[mi]), 64'(mq.size()));
    chk("src_valid", 64'(sv[mi]), 64'(mq.size() != 0));
    chk("head_prio", 64'(sp[mi]), mq.size() != 0 ? 64'(mq[0].p) : 64'd0);
    chk("head_data", 64'(sd[mi]), mq.size() != 0 ? 64'(mq[0].d) : 64'd0);
    chk("drop", 64'(drp[mi]), 64'(edrop));
  endtask

  function automatic vec_t mk(bit m, bit r, bit push, bit pop, logic [31:0] p,
                              logic [9:0] d, int ecnt, logic [31:0] eh);
    vec_t x;
    x.m = m; x.r = r; x.push = push; x.pop = pop; x.p = p; x.d = d;
    x.ecnt = ecnt; x.ehead = eh;
    return x;
  endfunction

  initial begin
    v[0] = 1'b0; v[1] = 1'b0; rdy[0] = 1'b0; rdy[1] = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("init_count", 64'(cnt[i]), 0);
      chk("init_valid", 64'(sv[i]), 0);
      chk("init_prio",  64'(sp[i]), 0);
      chk("init_ready", 64'(srd[i]), 1);
      chk("init_drop",  64'(drp[i]), 0);
    end

    // reject mode: ordering, full back-pressure, empty pops
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 5, 1, 1, 5));
    tbl.push_back(mk(0, 0, 1, 0, 9, 2, 2, 9));
    tbl.push_back(mk(0, 0, 1, 0, 1, 3, 3, 9));
    tbl.push_back(mk(0, 0, 1, 0, 7, 4, 4, 9));
    tbl.push_back(mk(0, 0, 1, 0, 2, 5, 4, 9));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 3, 7));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2, 5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // equal priorities drain in arrival order
    tbl.push_back(mk(0, 0, 1, 0, 3, 10, 1, 3));
    tbl.push_back(mk(0, 0, 1, 0, 3, 11, 2, 3));
    tbl.push_back(mk(0, 0, 1, 0, 3, 12, 3, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    // reset with push and pop pending, count=3
    tbl.push_back(mk(0, 0, 1, 0, 4, 20, 1, 4));
    tbl.push_back(mk(0, 0, 1, 0, 2, 21, 2, 4));
    tbl.push_back(mk(0, 0, 1, 0, 6, 22, 3, 6));
    tbl.push_back(mk(0, 1, 1, 1, 8, 23, 0, 0));
    // evict mode
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 9, 1, 1, 9));
    tbl.push_back(mk(1, 0, 1, 0, 7, 2, 2, 9));
    tbl.push_back(mk(1, 0, 1, 0, 5, 3, 3, 9));
    tbl.push_back(mk(1, 0, 1, 0, 1, 4, 4, 9));
    tbl.push_back(mk(1, 0, 1, 1, 8, 5, 4, 8));
    tbl.push_back(mk(1, 0, 1, 0, 6, 6, 4, 8));
    tbl.push_back(mk(1, 0, 1, 0, 5, 7, 4, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4, 8));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 3, 7));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 2, 6));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 5));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 30, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      do_op(tbl[i].m, tbl[i].r, tbl[i].push, tbl[i].pop, tbl[i].p, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), 64'(cnt[tbl[i].m ? 1 : 0]), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_head", i), 64'(sp[tbl[i].m ? 1 : 0]), 64'(tbl[i].ehead));
    end

    // reject mode, full: push alongside pop is back-pressured, only the pop happens
    do_op(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_op(0, 0, 1, 0, 32'(10 + i), 10'(40 + i));
    do_op(0, 0, 1, 1, 100, 50);
    chk("bp_count", 64'(cnt[0]), 3);
    chk("bp_head", 64'(sp[0]), 12);

    // evict mode: back-to-back losing pushes pulse drop each cycle, then it falls
    do_op(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_op(1, 0, 1, 0, 32'(20 - i), 10'(60 + i));
    do_op(1, 0, 1, 0, 3, 70);
    chk("drop_a", 64'(drp[1]), 1);
    do_op(1, 0, 1, 0, 17, 71);
    chk("drop_b", 64'(drp[1]), 1);
    do_op(1, 0, 0, 0, 0, 0);
    chk("drop_c", 64'(drp[1]), 0);
    chk("drop_count", 64'(cnt[1]), 4);

    // random mix against the model, small priority range to force ties
    for (int m = 0; m < 2; m++) begin
      do_op(bit'(m), 1, 0, 0, 0, 0);
      repeat (300) begin
        logic [31:0] rp;
        rp = 32'($urandom_range(0, 7));
        do_op(bit'(m), 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, rp,
              10'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
